// File: rtl/if_prefetch.sv
// Instruction-fetch stage with a DEPTH-slot prefetch queue.
// Issues sequential fetches, buffers PC/IR pairs for decode, and flushes on branch redirects.
module if_prefetch #(
   parameter int unsigned           WIDTH    = 32,
   parameter int unsigned           ADDR_W   = 32,
   parameter int unsigned           DEPTH    = 4,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [WIDTH-1:0]  imem_rsp_data,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_pc,
   output logic [WIDTH-1:0]  out_ir,
   input  logic              out_ready,
   input  logic              branch_valid,
   input  logic [ADDR_W-1:0] branch_addr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] slot_pc     [DEPTH];
   logic [WIDTH-1:0]  slot_ir     [DEPTH];
   logic              slot_filled [DEPTH];
   logic [PTR_W-1:0]  alloc_ptr, fill_ptr, head_ptr;
   logic [CNT_W-1:0]  alloc_cnt, out_cnt, drop_cnt;
   logic              branch_valid_q;

   logic              req_fire, pop, fill_en;
   logic [CNT_W-1:0]  out_cnt_nxt, alloc_cnt_nxt, drop_cnt_nxt;

   // Handshakes: a transfer happens on any cycle where valid and ready are both high.
   assign imem_req_valid = (alloc_cnt < CNT_MAX) && (out_cnt < CNT_MAX) && !branch_valid_q;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign out_valid      = (alloc_cnt != '0) && slot_filled[head_ptr];
   assign out_pc         = slot_pc[head_ptr];
   assign out_ir         = slot_ir[head_ptr];
   assign pop            = out_valid && out_ready;
   assign fill_en        = imem_rsp_valid && (drop_cnt == '0) && !branch_valid;

   always_comb begin
      out_cnt_nxt   = out_cnt;
      alloc_cnt_nxt = alloc_cnt;
      drop_cnt_nxt  = drop_cnt;
      if (req_fire)       out_cnt_nxt = out_cnt_nxt + CNT_ONE;
      if (imem_rsp_valid) out_cnt_nxt = out_cnt_nxt - CNT_ONE;
      if (req_fire)       alloc_cnt_nxt = alloc_cnt_nxt + CNT_ONE;
      if (pop)            alloc_cnt_nxt = alloc_cnt_nxt - CNT_ONE;
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - CNT_ONE;
      // Every request still outstanding after a redirect belongs to the old path.
      if (branch_valid) begin
         alloc_cnt_nxt = '0;
         drop_cnt_nxt  = out_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc       <= RESET_PC;
         alloc_ptr      <= '0;
         fill_ptr       <= '0;
         head_ptr       <= '0;
         alloc_cnt      <= '0;
         out_cnt        <= '0;
         drop_cnt       <= '0;
         branch_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_pc[i]     <= '0;
            slot_ir[i]     <= '0;
            slot_filled[i] <= 1'b0;
         end
      end else begin
         branch_valid_q <= branch_valid;
         out_cnt        <= out_cnt_nxt;
         alloc_cnt      <= alloc_cnt_nxt;
         drop_cnt       <= drop_cnt_nxt;
         if (req_fire) begin
            slot_pc[alloc_ptr]     <= fetch_pc;
            slot_filled[alloc_ptr] <= 1'b0;
         end
         if (fill_en) begin
            slot_ir[fill_ptr]     <= imem_rsp_data;
            slot_filled[fill_ptr] <= 1'b1;
         end
         if (branch_valid) begin
            fetch_pc  <= branch_addr & ~ADDR_W'(3);
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc  <= fetch_pc + ADDR_W'(4);
               alloc_ptr <= alloc_ptr + PTR_ONE;
            end
            if (fill_en) fill_ptr <= fill_ptr + PTR_ONE;
            if (pop)     head_ptr <= head_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a latency-configurable in-order memory model, a scoreboard of
// expected decode PCs, a per-cycle vector table, directed corner cases and random traffic.
module tb_if_prefetch;

   localparam int          WIDTH    = 32;
   localparam int          ADDR_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              imem_req_valid;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_req_ready;
   logic              imem_rsp_valid;
   logic [WIDTH-1:0]  imem_rsp_data;
   logic              out_valid;
   logic [ADDR_W-1:0] out_pc;
   logic [WIDTH-1:0]  out_ir;
   logic              out_ready;
   logic              branch_valid;
   logic [ADDR_W-1:0] branch_addr;

   if_prefetch #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .out_valid(out_valid), .out_pc(out_pc), .out_ir(out_ir), .out_ready(out_ready),
      .branch_valid(branch_valid), .branch_addr(branch_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_t;

   typedef struct {
      logic        out_ready;
      logic        req_valid;
      logic [31:0] req_addr;
      logic        out_valid;
      logic [31:0] out_pc;
      logic [31:0] out_ir;
      logic        chk_data;
   } vec_t;

   mem_t        mem_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_req_pc;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rdy_pct = 100;
   int          lat_lo = 1;
   int          lat_extra = 0;
   int          delivered = 0;
   int          fires = 0;
   bit          just_reset = 0;
   bit          prev_branch = 0;
   bit          wrap_seen = 0;
   logic        s_req_valid, s_out_valid;
   logic [31:0] s_req_addr, s_out_pc, s_out_ir;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive memory, sample at negedge, score, then advance the memory model.
   task automatic tick();
      logic        fire, pop;
      logic [31:0] e;
      imem_req_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_data(mem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
      s_req_valid = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_out_valid = out_valid;
      s_out_pc    = out_pc;
      s_out_ir    = out_ir;
      fire = s_req_valid && imem_req_ready;
      pop  = s_out_valid && out_ready;
      if (rst_n) begin
         if (just_reset) begin
            chk("rst_out_valid", 64'(s_out_valid), 64'd0);
            chk("rst_req_valid", 64'(s_req_valid), 64'd1);
            chk("rst_req_addr", 64'(s_req_addr), 64'(RESET_PC));
         end
         if (prev_branch) chk("branch_req_gap", 64'(s_req_valid), 64'd0);
         if (fire) begin
            chk("req_addr", 64'(s_req_addr), 64'(exp_req_pc));
            chk("outstanding_bound", 64'(mem_q.size() < DEPTH), 64'd1);
            chk("alloc_bound", 64'(exp_q.size() < DEPTH), 64'd1);
            if (s_req_addr == 32'h0 && !just_reset) wrap_seen = 1;
         end
         if (pop) begin
            delivered++;
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", 64'(s_out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("out_pc", 64'(s_out_pc), 64'(e));
               chk("out_ir", 64'(s_out_ir), 64'(mem_data(e)));
            end
         end
         if (fire) begin
            fires++;
            if (!branch_valid) exp_q.push_back(exp_req_pc);
            exp_req_pc = exp_req_pc + 32'd4;
         end
         if (branch_valid) begin
            exp_q.delete();
            exp_req_pc = branch_addr & ~32'd3;
         end
      end
      @(posedge clk);
      #1;
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (!rst_n) begin
         mem_q.delete();
         exp_q.delete();
         exp_req_pc  = RESET_PC;
         just_reset  = 1;
         prev_branch = 0;
      end else begin
         if (fire) mem_q.push_back('{addr: s_req_addr, due: cyc + lat_lo + $urandom_range(0, lat_extra)});
         just_reset  = 0;
         prev_branch = branch_valid;
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      branch_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[16];
      int   n, d0;
      rst_n = 1'b0; out_ready = 1'b1; branch_valid = 1'b0; branch_addr = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

      // Per-cycle vectors from reset: 1-cycle memory, decode stalls for cycles 6..9.
      for (int i = 0; i < 16; i++) begin
         tbl[i].out_ready = (i < 6 || i >= 10);
         tbl[i].req_valid = !(i >= 8 && i <= 10);
         tbl[i].req_addr  = (i <= 7) ? 32'(4 * i) : (i <= 11) ? 32'd32 : 32'(32 + 4 * (i - 11));
         tbl[i].out_valid = (i >= 2);
         tbl[i].out_pc    = (i < 2) ? 32'd0 : (i <= 5) ? 32'(4 * (i - 2)) :
                            (i <= 10) ? 32'd16 : 32'(20 + 4 * (i - 11));
         tbl[i].out_ir    = (i == 0) ? 32'd0 : mem_data(tbl[i].out_pc);
         tbl[i].chk_data  = (i == 0) || tbl[i].out_valid;
      end
      rdy_pct = 100; lat_lo = 1; lat_extra = 0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         out_ready = tbl[i].out_ready;
         tick();
         chk("tbl_req_valid", 64'(s_req_valid), 64'(tbl[i].req_valid));
         chk("tbl_req_addr", 64'(s_req_addr), 64'(tbl[i].req_addr));
         chk("tbl_out_valid", 64'(s_out_valid), 64'(tbl[i].out_valid));
         if (tbl[i].chk_data) begin
            chk("tbl_out_pc", 64'(s_out_pc), 64'(tbl[i].out_pc));
            chk("tbl_out_ir", 64'(s_out_ir), 64'(tbl[i].out_ir));
         end
      end

      // Decode stalled from reset: exactly DEPTH requests, head held at PC 0, then ordered drain.
      do_reset();
      out_ready = 1'b0;
      n = fires;
      for (int i = 0; i < 10; i++) tick();
      chk("stall_req_count", 64'(fires - n), 64'(DEPTH));
      chk("stall_req_valid", 64'(s_req_valid), 64'd0);
      chk("stall_out_valid", 64'(s_out_valid), 64'd1);
      chk("stall_out_pc", 64'(s_out_pc), 64'd0);
      out_ready = 1'b1;
      d0 = delivered;
      for (int i = 0; i < 4; i++) tick();
      chk("stall_drain_count", 64'(delivered - d0), 64'd4);

      // 3-cycle memory, three requests in flight, redirect to 0x103.
      lat_lo = 3;
      do_reset();
      tick();
      tick();
      branch_valid = 1'b1; branch_addr = 32'h103;
      tick();
      branch_valid = 1'b0;
      chk("br3_inflight", 64'(mem_q.size()), 64'd3);
      for (int i = 3; i <= 7; i++) begin
         tick();
         chk("br3_no_stale_out", 64'(s_out_valid), 64'd0);
         if (i == 4) begin
            chk("br3_req_valid", 64'(s_req_valid), 64'd1);
            chk("br3_req_addr", 64'(s_req_addr), 64'h100);
         end
      end
      tick();
      chk("br3_first_valid", 64'(s_out_valid), 64'd1);
      chk("br3_first_pc", 64'(s_out_pc), 64'h100);

      // Redirect in the same cycle as a response and a decode transfer.
      lat_lo = 1;
      do_reset();
      for (int i = 0; i < 6; i++) tick();
      branch_valid = 1'b1; branch_addr = 32'h200;
      d0 = delivered;
      tick();
      branch_valid = 1'b0;
      chk("brx_transfer_done", 64'(delivered - d0), 64'd1);
      chk("brx_rsp_present", 64'(imem_rsp_valid), 64'd1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("brx_flushed", 64'(s_out_valid), 64'd0);
      end
      tick();
      chk("brx_new_valid", 64'(s_out_valid), 64'd1);
      chk("brx_new_pc", 64'(s_out_pc), 64'h200);

      // PC wrap at the top of the address space with random memory readiness.
      rdy_pct = 60; lat_lo = 1; lat_extra = 2;
      branch_valid = 1'b1; branch_addr = 32'hFFFF_FFF2;
      tick();
      branch_valid = 1'b0;
      wrap_seen = 0;
      d0 = delivered;
      for (int i = 0; i < 60; i++) begin
         out_ready = ($urandom_range(0, 99) < 70);
         tick();
      end
      chk("wrap_seen", 64'(wrap_seen), 64'd1);
      chk("wrap_progress", 64'(delivered - d0 >= 6), 64'd1);

      // Reset for one cycle while the queue is full.
      rdy_pct = 100; lat_lo = 1; lat_extra = 0; out_ready = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("full_before_reset", 64'(s_req_valid), 64'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("mid_rst_out_valid", 64'(s_out_valid), 64'd0);
      chk("mid_rst_req_addr", 64'(s_req_addr), 64'(RESET_PC));

      // Random traffic with occasional redirects.
      d0 = delivered;
      for (int i = 0; i < 500; i++) begin
         rdy_pct      = $urandom_range(30, 100);
         lat_lo       = $urandom_range(1, 2);
         lat_extra    = $urandom_range(0, 3);
         out_ready    = ($urandom_range(0, 99) < 75);
         branch_valid = ($urandom_range(0, 99) < 4);
         branch_addr  = $urandom;
         tick();
      end
      branch_valid = 1'b0;
      chk("random_progress", 64'(delivered - d0 >= 50), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
